// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types, widths and helpers
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rf_wb_arb_if.sv
// rtl/rf_wb_arb_if.sv - writeback sources, register-file write port and forwarding lookup
interface rf_wb_arb_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             i_a_valid;
    logic             o_a_ready;
    logic [4:0]       i_a_addr;
    logic [31:0]      i_a_data;
    logic             i_b_valid;
    logic             o_b_ready;
    logic [4:0]       i_b_addr;
    logic [31:0]      i_b_data;
    logic             o_rd_wen;
    logic [4:0]       o_rd_waddr;
    logic [31:0]      o_rd_wdata;
    logic [31:0]      o_pending;
    logic [PTR_W:0]   o_count;
    logic [4:0]       i_fwd_addr;
    logic             o_fwd_hit;
    logic [31:0]      o_fwd_data;

    // Sources and issue logic drive requests and lookups.
    modport master (
        output i_a_valid, i_a_addr, i_a_data,
        output i_b_valid, i_b_addr, i_b_data,
        output i_fwd_addr,
        input  o_a_ready, o_b_ready, o_rd_wen, o_rd_waddr, o_rd_wdata,
        input  o_pending, o_count, o_fwd_hit, o_fwd_data
    );

    // The arbiter accepts requests and drives the write port.
    modport slave (
        input  i_a_valid, i_a_addr, i_a_data,
        input  i_b_valid, i_b_addr, i_b_data,
        input  i_fwd_addr,
        output o_a_ready, o_b_ready, o_rd_wen, o_rd_waddr, o_rd_wdata,
        output o_pending, o_count, o_fwd_hit, o_fwd_data
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - source-B writeback FIFO with all entries visible to the arbiter
module wb_fifo
    import rf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  wb_req_t                push_req_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [PTR_W:0]         count_o,
    output logic [PTR_W-1:0]       rd_ptr_o,
    output wb_req_t [DEPTH-1:0]    entries_o
);

    wb_req_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      count_q,  count_d;

    // Next pointers and occupancy; power-of-two depth makes pointer wrap free.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale slots are masked by occupancy, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - register-file writeback arbiter; RF_WB_FWD_EN enables forwarding lookup
module rf_wb_arb
    import rf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    rf_wb_arb_if.slave  bus
);

    logic                  full, empty;
    logic [PTR_W:0]        count;
    logic [PTR_W-1:0]      rd_ptr;
    wb_req_t [DEPTH-1:0]   entries;
    wb_req_t               head;
    wb_req_t               b_req;
    logic                  a_fire, b_fire, push, pop;
    logic [DEPTH-1:0]      ent_valid;

    logic                  wen_q,   wen_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;

    assign bus.o_a_ready = !full;
    assign bus.o_b_ready = !full;
    assign a_fire        = bus.i_a_valid && !full;
    assign b_fire        = bus.i_b_valid && !full;
    // x0 writes are accepted but dropped, so the FIFO never holds address 0.
    assign push          = b_fire && (bus.i_b_addr != '0);
    assign pop           = !a_fire && !empty;
    assign b_req         = '{addr: bus.i_b_addr, data: bus.i_b_data};
    assign head          = entries[rd_ptr];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (i_clk),
        .rst_n_i    (i_rst_n),
        .push_i     (push),
        .push_req_i (b_req),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .rd_ptr_o   (rd_ptr),
        .entries_o  (entries)
    );

    // Write-port select: A has priority, otherwise drain the FIFO head.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (a_fire) begin
            if (bus.i_a_addr != '0) begin
                wen_d   = 1'b1;
                waddr_d = bus.i_a_addr;
                wdata_d = bus.i_a_data;
            end
        end else if (pop) begin
            wen_d   = 1'b1;
            waddr_d = head.addr;
            wdata_d = head.data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.o_rd_wen   = wen_q;
    assign bus.o_rd_waddr = waddr_q;
    assign bus.o_rd_wdata = wdata_q;
    assign bus.o_count    = count;

    // Occupied FIFO slots: distance from the read pointer below the count.
    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
        end
    end

    // Pending mask over queued entries plus the in-flight output register.
    always_comb begin
        logic [NUM_REGS-1:0] pend;
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pend = pend | onehot_reg(entries[i].addr);
            end
        end
        if (wen_q) begin
            pend = pend | onehot_reg(waddr_q);
        end
        pend[0] = 1'b0;
        bus.o_pending = pend;
    end

`ifdef RF_WB_FWD_EN
    // Forwarding lookup: scan oldest to youngest so the youngest match wins,
    // then let the output register override as the most recent value.
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.o_fwd_hit  = 1'b0;
        bus.o_fwd_data = '0;
        if (bus.i_fwd_addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PTR_W'(k);
                if (((PTR_W+1)'(k) < count) && (entries[idx].addr == bus.i_fwd_addr)) begin
                    bus.o_fwd_hit  = 1'b1;
                    bus.o_fwd_data = entries[idx].data;
                end
            end
            if (wen_q && (waddr_q == bus.i_fwd_addr)) begin
                bus.o_fwd_hit  = 1'b1;
                bus.o_fwd_data = wdata_q;
            end
        end
    end
`else
    assign bus.o_fwd_hit  = 1'b0;
    assign bus.o_fwd_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - randomized bench for rf_wb_arb against a queue-level model
module tb_rf_wb_arb;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arb_if #(.DEPTH(DEPTH)) bus ();

    rf_wb_arb #(.DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].a] = 1'b1;
        if (m_wen) p[m_waddr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Compare every DUT output against the model's current state.
    task automatic check_all();
        logic        rdy;
        logic        fhit;
        logic [31:0] fdata;
        rdy   = (q.size() < DEPTH);
        fhit  = 1'b0;
        fdata = '0;
`ifdef RF_WB_FWD_EN
        if (bus.i_fwd_addr != 0) begin
            if (m_wen && m_waddr == bus.i_fwd_addr) begin
                fhit = 1'b1; fdata = m_wdata;
            end else begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].a == bus.i_fwd_addr) begin
                        fhit = 1'b1; fdata = q[i].d;
                        break;
                    end
                end
            end
        end
`endif
        chk("a_ready",  32'(bus.o_a_ready),  32'(rdy));
        chk("b_ready",  32'(bus.o_b_ready),  32'(rdy));
        chk("count",    32'(bus.o_count),    32'(q.size()));
        chk("pending",  bus.o_pending,       exp_pending());
        chk("rd_wen",   32'(bus.o_rd_wen),   32'(m_wen));
        chk("rd_waddr", 32'(bus.o_rd_waddr), 32'(m_waddr));
        chk("rd_wdata", bus.o_rd_wdata,      m_wdata);
        chk("fwd_hit",  32'(bus.o_fwd_hit),  32'(fhit));
        chk("fwd_data", bus.o_fwd_data,      fdata);
    endtask

    // Advance the model by one clock edge from the applied inputs.
    task automatic model_next(input logic rst, input logic av, input logic [4:0] aa,
                              input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                              input logic [31:0] bd);
        logic rdy;
        if (!rst) begin
            q.delete();
            m_wen = 0; m_waddr = 0; m_wdata = 0;
            return;
        end
        rdy = (q.size() < DEPTH);
        if (av && rdy) begin
            m_wen = (aa != 0);
            if (aa != 0) begin m_waddr = aa; m_wdata = ad; end
        end else if (q.size() > 0) begin
            m_wen = 1; m_waddr = q[0].a; m_wdata = q[0].d;
            void'(q.pop_front());
        end else begin
            m_wen = 0;
        end
        if (bv && rdy && ba != 0) q.push_back('{a: ba, d: bd});
    endtask

    task automatic step(input logic rst, input logic av, input logic [4:0] aa,
                        input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                        input logic [31:0] bd, input logic [4:0] fa);
        rst_n          = rst;
        bus.i_a_valid  = av; bus.i_a_addr = aa; bus.i_a_data = ad;
        bus.i_b_valid  = bv; bus.i_b_addr = ba; bus.i_b_data = bd;
        bus.i_fwd_addr = fa;
        #1;
        if (chk_en) check_all();
        model_next(rst, av, aa, ad, bv, ba, bd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    initial begin
        m_wen = 0; m_waddr = 0; m_wdata = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        chk("reset_count",   32'(bus.o_count),   32'd0);
        chk("reset_wen",     32'(bus.o_rd_wen),  32'd0);
        chk("reset_pending", bus.o_pending,      32'd0);

        // Single A write, one-cycle latency.
        step(1, 1, 5, 32'h1234, 0, 0, 0, 0);
        chk("a_lat_wen",   32'(bus.o_rd_wen),   32'd1);
        chk("a_lat_addr",  32'(bus.o_rd_waddr), 32'd5);
        chk("a_lat_data",  bus.o_rd_wdata,      32'h1234);
        chk("a_lat_pend",  bus.o_pending,       32'h0000_0020);
        idle();
        chk("a_after_pend", bus.o_pending,      32'd0);
        chk("a_after_wen",  32'(bus.o_rd_wen),  32'd0);

        // B queues behind a busy A, then drains in order.
        step(1, 1, 1, 32'h11, 1, 7, 32'hA, 0);
        step(1, 1, 2, 32'h22, 1, 8, 32'hB, 0);
        chk("b_q_count", 32'(bus.o_count),    32'd2);
        chk("b_q_p7",    32'(bus.o_pending[7]), 32'd1);
        chk("b_q_p8",    32'(bus.o_pending[8]), 32'd1);
        step(1, 1, 3, 32'h33, 0, 0, 0, 0);
        idle();
        chk("drain1_addr", 32'(bus.o_rd_waddr), 32'd7);
        chk("drain1_data", bus.o_rd_wdata,      32'hA);
        idle();
        chk("drain2_addr", 32'(bus.o_rd_waddr), 32'd8);
        chk("drain2_data", bus.o_rd_wdata,      32'hB);
        idle();

        // Fill to DEPTH, then the forced drain cycle.
        for (int i = 0; i < DEPTH; i++) step(1, 1, 5'(10 + i), 32'(i), 1, 5'(20 + i), 32'(100 + i), 0);
        chk("full_a_ready", 32'(bus.o_a_ready), 32'd0);
        chk("full_b_ready", 32'(bus.o_b_ready), 32'd0);
        chk("full_count",   32'(bus.o_count),   32'd4);
        step(1, 1, 15, 32'h55, 1, 25, 32'h66, 0);
        chk("forced_pop_addr", 32'(bus.o_rd_waddr), 32'd20);
        chk("forced_pop_cnt",  32'(bus.o_count),    32'd3);
        chk("forced_pop_rdy",  32'(bus.o_a_ready),  32'd1);
        repeat (5) idle();

        // Writes to x0 from both sources.
        step(1, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0);
        chk("x0_wen",   32'(bus.o_rd_wen), 32'd0);
        chk("x0_count", 32'(bus.o_count),  32'd0);
        chk("x0_pend",  bus.o_pending,     32'd0);

        // Reset with queued entries and an active write.
        for (int i = 0; i < 3; i++) step(1, 1, 5'(1 + i), 32'(i), 1, 5'(4 + i), 32'(i), 0);
        step(0, 1, 9, 32'h9, 1, 10, 32'hA, 0);
        chk("rst_wen",   32'(bus.o_rd_wen),   32'd0);
        chk("rst_addr",  32'(bus.o_rd_waddr), 32'd0);
        chk("rst_data",  bus.o_rd_wdata,      32'd0);
        chk("rst_count", 32'(bus.o_count),    32'd0);
        chk("rst_pend",  bus.o_pending,       32'd0);
        repeat (3) idle();
        chk("rst_no_drain", 32'(bus.o_rd_wen), 32'd0);

        // Forwarding lookup with two queued writes to x9.
        step(1, 1, 3, 32'h3, 1, 9, 32'h1, 0);
        step(1, 1, 4, 32'h4, 1, 9, 32'h2, 0);
        bus.i_a_valid  = 1; bus.i_a_addr = 5; bus.i_b_valid = 0;
        bus.i_fwd_addr = 9;
        #1;
`ifdef RF_WB_FWD_EN
        chk("fwd9_hit",  32'(bus.o_fwd_hit), 32'd1);
        chk("fwd9_data", bus.o_fwd_data,     32'h2);
`else
        chk("fwd9_hit",  32'(bus.o_fwd_hit), 32'd0);
        chk("fwd9_data", bus.o_fwd_data,     32'h0);
`endif
        bus.i_fwd_addr = 0;
        #1;
        chk("fwd0_hit", 32'(bus.o_fwd_hit), 32'd0);
        repeat (4) idle();

        // Randomized traffic with varying A load.
        for (int n = 0; n < 3000; n++) begin
            int a_pct;
            a_pct = (n / 500) % 2 == 0 ? 85 : 40;
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) < a_pct), rand_addr(), $urandom(),
                 ($urandom_range(0, 99) < 50),    rand_addr(), $urandom(),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_arb.md
Name: rf_wb_arb

Overview:
- Write-side master for the 32x32 register file: arbitrates register writebacks from the in-order pipeline (source A) and a long-latency unit such as a divider or load miss (source B), and drives the register file's single synchronous write port.
- Source B results are buffered in a small FIFO and drain when source A is idle.
- Exports a per-register pending mask so issue logic can stall on queued writes.

Parameters:
- DEPTH, 4, source-B FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  synchronous active-low reset
- i_a_valid  in  1  source A writeback request
- o_a_ready  out  1  source A accepted this cycle when valid&ready
- i_a_addr  in  5  source A destination register
- i_a_data  in  32  source A result
- i_b_valid  in  1  source B writeback request
- o_b_ready  out  1  FIFO can accept
- i_b_addr  in  5  source B destination register
- i_b_data  in  32  source B result
- o_rd_wen  out  1  register file write enable, registered
- o_rd_waddr  out  5  register file write address, registered
- o_rd_wdata  out  32  register file write data, registered
- o_pending  out  32  bit r set while any FIFO entry or the output register targets r; bit 0 always 0
- o_count  out  PTR_W+1  FIFO occupancy

Behaviour:
- Reset (i_rst_n=0 at the edge): FIFO empty, pointers 0, o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, o_pending=0, o_count=0. Reset wins over any accepted request in the same cycle.
- o_b_ready = (count < DEPTH). No same-cycle pass-through when full.
- o_a_ready = (count < DEPTH). A full FIFO forces one drain cycle, which bounds B latency.
- Per-cycle write-port select:
  - (1) A fire (i_a_valid && o_a_ready) → A.
  - (2) Otherwise, if count > 0 → FIFO head, which is popped.
  - (3) Otherwise → no write.
- Selected write is registered: the request accepted at edge k appears on o_rd_* during cycle k..k+1, and the register file commits at edge k+1. Fixed latency of 1 cycle for A; B latency is 1 + queueing.
- B fire pushes to the tail at the same edge as any pop. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Writes to address 0: accepted (ready semantics unchanged), never stored, never drive o_rd_wen, never set o_pending.
- A and B firing together: both accepted; A drives the port and B is enqueued.
- Order: B entries leave in arrival order. Ordering between A and B to the same register is the issuer's responsibility, enforced via o_pending.
- o_pending is combinational from FIFO valid entries OR (o_rd_wen ? onehot(o_rd_waddr) : 0).
- o_rd_wen deasserts in the cycle after the last write when no source is selected; address and data hold their last value.

Optional Feature:
- RF_WB_FWD_EN adds forwarding lookup ports: i_fwd_addr (in, 5), o_fwd_hit (out, 1), o_fwd_data (out, 32).
- With the macro: combinational lookup.
  - If o_rd_wen and o_rd_waddr match, hit with o_rd_wdata.
  - Otherwise, the youngest FIFO entry matching i_fwd_addr hits with its data.
  - Address 0 never hits.
- Without the macro: ports are present, o_fwd_hit=0, o_fwd_data=0, and no compare logic is generated.

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32
  - typedef wb_req_t {addr, data}
  - function onehot_reg(addr)
- Sub-module: wb_fifo (parameter DEPTH; push/pop/full/empty/count, entries exposed for the pending mask and the forwarding search). The arbiter and output register stay in rf_wb_arb.

Test Plan:
- Reset, then A writes x5=0x1234 for one cycle → next cycle o_rd_wen=1, o_rd_waddr=5, o_rd_wdata=0x1234; o_pending[5]=1 in that cycle only.
- B pushes x7=0xA, x8=0xB while A writes every cycle → FIFO holds both entries (o_count=2, o_pending[7]=o_pending[8]=1). When A drops, x7 then x8 are written in order on consecutive cycles.
- DEPTH=4, fill FIFO with A active continuously → o_b_ready=0 and o_a_ready=0 at count 4. The next cycle drains the head, and o_a_ready returns to 1 after the pop.
- A and B both valid to x0 → both ready, o_rd_wen stays 0, o_count unchanged, o_pending=0.
- Reset asserted with 3 entries queued and o_rd_wen=1 → after the edge all outputs are 0, and the queued entries are never written.
- RF_WB_FWD_EN: queue x9=0x1 then x9=0x2, i_fwd_addr=9 → o_fwd_hit=1, o_fwd_data=0x2. With i_fwd_addr=0 → o_fwd_hit=0.
